ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch stage feeding the decode unit. Holds the PC, issues one
//  word read per instruction to instruction memory over a valid/ready request
//  + response-valid interface, and presents {inst, inst_pc} to decode with a
//  valid/ready handshake. Accepts the resolved next PC and asynchronous flushes.
//  Stops fetching for good after ebreak (32'h0010_0073) is consumed.
// PARAMETERS
//  XLEN         32             datapath/address width
//  RESET_PC     32'h8000_0000  PC loaded on reset
//  EBREAK_INST  32'h0010_0073  encoding that halts fetch once consumed
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous, active-low reset
//  mem_req_valid  out  1     fetch request valid
//  mem_req_ready  in   1     memory accepts request
//  mem_req_addr   out  XLEN  fetch address (= pc)
//  mem_rsp_valid  in   1     read data valid (1-cycle pulse, no backpressure)
//  mem_rsp_data   in   32    fetched instruction word
//  inst_valid     out  1     instruction available to decode
//  inst_ready     in   1     decode consumes instruction
//  inst           out  32    instruction word to decode
//  inst_pc        out  XLEN  PC of inst
//  next_pc_valid  in   1     next_pc meaningful in consume cycle (taken branch/jump)
//  next_pc        in   XLEN  resolved next PC
//  flush_valid    in   1     redirect, any cycle, highest priority
//  flush_pc       in   XLEN  redirect target
//  halted         out  1     ebreak consumed or misaligned target; sticky
//  misaligned     out  1     PC target with [1:0]!=0 was seen; sticky
// BEHAVIOUR
//  - Reset: state=S_IDLE, pc=RESET_PC, inst_q=0, drop=0; all outputs 0 except
//    mem_req_addr/inst_pc=RESET_PC.
//  - FSM S_IDLE->S_REQ->S_WAIT->S_HOLD->S_REQ..., plus terminal S_HALT.
//    S_IDLE: one cycle, goes to S_REQ.
//    S_REQ: mem_req_valid=1, addr=pc, held stable until mem_req_ready; then S_WAIT.
//    S_WAIT: on mem_rsp_valid: if drop, clear drop and go S_REQ (data discarded);
//      else inst_q<=mem_rsp_data, go S_HOLD. Max one outstanding request.
//    S_HOLD: inst_valid=1, inst=inst_q, inst_pc=pc. On inst_valid&&inst_ready:
//      inst_q==EBREAK_INST -> S_HALT; else pc<=next_pc_valid?next_pc:pc+4, go S_REQ.
//    S_HALT: all valids 0, halted=1; exit only via reset.
//  - Best-case latency: request-accept to inst_valid = 1 cycle after mem_rsp_valid;
//    back-to-back instruction throughput 1 per 3 cycles with zero-wait memory.
//  - pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0).
//  - flush_valid (not in S_HALT) loads pc<=flush_pc next edge and wins over
//    next_pc/pc+4 and over ebreak consume in the same cycle:
//    S_REQ before acceptance: go S_REQ at new pc (addr changes, allowed: not accepted).
//    S_REQ same cycle as mem_req_ready: request is out -> drop<=1, go S_WAIT.
//    S_WAIT: drop<=1 unless mem_rsp_valid same cycle (then discard it), go S_REQ
//      only after the stale response is absorbed.
//    S_HOLD: inst_q discarded, inst_valid=0 next cycle, go S_REQ.
//  - Any PC load with [1:0]!=0 (flush_pc or next_pc): misaligned<=1, go S_HALT,
//    no request issued.
//  - mem_rsp_valid outside S_WAIT is ignored. inst/inst_pc stable while
//    inst_valid && !inst_ready.
// STRUCTURE
//  - Shared package: XLEN, RESET_PC, EBREAK_INST, state encoding localparams.
//  - Sub-module ifu_pc_reg: pc register with async reset, next-pc select
//    (flush > next_pc > pc+4) and misalignment check. FSM stays in ifu_fetch.
// TESTING
//  1 Reset release, zero-wait mem returning 32'h0010_0093 -> req addr 8000_0000,
//    inst_valid 1 cycle after rsp, inst_pc 8000_0000; after consume req addr 8000_0004.
//  2 mem_req_ready low 5 cycles -> addr/valid stable 5 cycles, one accept only.
//  3 Consume with next_pc_valid=1, next_pc=8000_0100 -> next req addr 8000_0100.
//  4 flush_pc=8000_0200 in S_WAIT, rsp 32'hDEAD_BEEF 3 cycles later -> data never
//    on inst; next req addr 8000_0200.
//  5 Consume 32'h0010_0073 -> halted=1, no further mem_req_valid for 20 cycles;
//    rst_n low mid-S_WAIT -> outputs at reset values immediately.
//  6 flush_pc=8000_0002 -> misaligned=1, halted=1, no request; pc=FFFF_FFFC
//    consume -> next addr 0000_0000.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM state encoding lives here so the bench and RTL agree.
package ifu_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  function automatic logic is_misaligned(
    input logic [XLEN-1:0] a
  );
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Memory request/response, decode handshake and redirect bundle.
// master = fetch unit, slave = memory/decode/branch environment.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            next_pc_valid;
  logic [XLEN-1:0] next_pc;
  logic            flush_valid;
  logic [XLEN-1:0] flush_pc;
  logic            halted;
  logic            misaligned;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready,
    input  next_pc_valid,
    input  next_pc,
    input  flush_valid,
    input  flush_pc,
    output halted,
    output misaligned
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready,
    output next_pc_valid,
    output next_pc,
    output flush_valid,
    output flush_pc,
    input  halted,
    input  misaligned
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// Program counter with flush > next_pc > pc+4 select.
// Flags any load of a target whose low two bits are nonzero.
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  input  logic            i_adv,
  input  logic            i_npc_valid,
  input  logic [XLEN-1:0] i_npc,
  output logic [XLEN-1:0] o_pc,
  output logic            o_mis,
  output logic            o_misaligned
);

  logic [XLEN-1:0] r_pc;
  logic            r_misaligned;
  logic [XLEN-1:0] w_next;
  logic            w_load;

  // pc+4 wraps naturally at the top of the address space
  assign w_next = i_flush     ? i_flush_pc :
                  i_npc_valid ? i_npc      :
                  r_pc + XLEN'(4);

  assign w_load = i_flush | i_adv;
  assign o_mis  = w_load && is_misaligned(w_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= P_RESET_PC;
      r_misaligned <= 1'b0;
    end else begin
      if (w_load) r_pc <= w_next;
      if (o_mis)  r_misaligned <= 1'b1;
    end
  end

  assign o_pc         = r_pc;
  assign o_misaligned = r_misaligned;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word read, one instruction
// held for decode, redirect via flush/next_pc, permanent halt on ebreak.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] P_RESET_PC = RESET_PC,
  parameter logic [31:0]     P_EBREAK   = EBREAK_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [31:0]     r_inst_q;
  logic            w_inst_ld;
  logic [XLEN-1:0] w_pc;
  logic            w_mis;
  logic            w_misaligned;
  logic            w_flush;
  logic            w_consume;
  logic            w_ebreak;
  logic            w_adv;

  assign w_flush   = bus.flush_valid && (r_state != S_HALT);
  assign w_consume = (r_state == S_HOLD) && bus.inst_ready;
  assign w_ebreak  = (r_inst_q == P_EBREAK);
  assign w_adv     = w_consume && !w_flush && !w_ebreak;

  ifu_pc_reg #(
    .P_RESET_PC (P_RESET_PC)
  ) u_pc (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (w_flush),
    .i_flush_pc   (bus.flush_pc),
    .i_adv        (w_adv),
    .i_npc_valid  (bus.next_pc_valid),
    .i_npc        (bus.next_pc),
    .o_pc         (w_pc),
    .o_mis        (w_mis),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_drop   <= 1'b0;
      r_inst_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (w_inst_ld) r_inst_q <= bus.mem_rsp_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_inst_ld   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = w_mis ? S_HALT : S_REQ;
      end
      S_REQ: begin
        if (w_flush) begin
          // an accepted request still owes us a response
          if (bus.mem_req_ready) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT;
          end
          if (w_mis) w_state_nxt = S_HALT;
        end else if (bus.mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_flush) begin
          if (w_mis) begin
            w_state_nxt = S_HALT;
          end else if (bus.mem_rsp_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (bus.mem_rsp_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_inst_ld   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_flush) begin
          w_state_nxt = w_mis ? S_HALT : S_REQ;
        end else if (bus.inst_ready) begin
          if (w_ebreak) w_state_nxt = S_HALT;
          else          w_state_nxt = w_mis ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  assign bus.mem_req_valid = (r_state == S_REQ);
  assign bus.mem_req_addr  = w_pc;
  assign bus.inst_valid    = (r_state == S_HOLD);
  assign bus.inst          = r_inst_q;
  assign bus.inst_pc       = w_pc;
  assign bus.halted        = (r_state == S_HALT);
  assign bus.misaligned    = w_misaligned;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: vector table plus redirect/halt sequences.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   accepts;
  logic saw_bad;

  ifu_fetch_if bus();

  ifu_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && bus.mem_req_valid && bus.mem_req_ready)
      accepts <= accepts + 1;

  always @(negedge clk)
    if (bus.inst_valid && bus.inst == 32'hDEAD_BEEF)
      saw_bad <= 1'b1;

  typedef struct {
    logic [31:0] data;
    logic        npv;
    logic [31:0] np;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!bus.mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, bus.mem_req_valid}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr,
                          input logic [31:0] data,
                          input int stall,
                          input logic npv,
                          input logic [31:0] np,
                          input logic consume);
    int a0;
    wait_req();
    chk("req_addr", bus.mem_req_addr, exp_addr);
    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("stall_addr", bus.mem_req_addr, exp_addr);
    end
    a0 = accepts;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("one_accept", accepts - a0, 32'd1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = data;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("inst_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("inst", bus.inst, data);
    chk("inst_pc", bus.inst_pc, exp_addr);
    if (consume) begin
      bus.inst_ready    = 1'b1;
      bus.next_pc_valid = npv;
      bus.next_pc       = np;
      @(negedge clk);
      bus.inst_ready    = 1'b0;
      bus.next_pc_valid = 1'b0;
    end
  endtask

  task automatic no_req(input string name, input int cyc);
    int n;
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid) n++;
    end
    chk(name, n, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    accepts  = 0;
    saw_bad  = 1'b0;
    rst_n    = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.inst_ready    = 1'b0;
    bus.next_pc_valid = 1'b0;
    bus.next_pc       = '0;
    bus.flush_valid   = 1'b0;
    bus.flush_pc      = '0;

    vecs[0] = '{32'h0010_0093, 1'b0, 32'h0, 32'h8000_0000};
    vecs[1] = '{32'h0000_0013, 1'b1, 32'h8000_0100, 32'h8000_0004};
    vecs[2] = '{32'h0020_0113, 1'b0, 32'h0, 32'h8000_0100};
    vecs[3] = '{32'h0030_0193, 1'b1, 32'hFFFF_FFFC, 32'h8000_0104};
    vecs[4] = '{32'h0040_0213, 1'b0, 32'h0, 32'hFFFF_FFFC};
    vecs[5] = '{32'h0050_0293, 1'b0, 32'h0, 32'h0000_0000};

    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_addr", bus.mem_req_addr, RESET_PC);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, RESET_PC);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_misaligned", {31'd0, bus.misaligned}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      do_fetch(vecs[i].addr, vecs[i].data, 0, vecs[i].npv,
               vecs[i].np, 1'b1);

    // backpressured request at the wrapped pc
    do_fetch(32'h0000_0004, 32'h0060_0313, 5, 1'b0, 32'h0, 1'b1);

    // flush while the response is outstanding
    wait_req();
    chk("wait_addr", bus.mem_req_addr, 32'h0000_0008);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    bus.flush_valid   = 1'b1;
    bus.flush_pc      = 32'h8000_0200;
    @(negedge clk);
    bus.flush_valid = 1'b0;
    chk("flw_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    @(negedge clk);
    chk("flw_no_req", {31'd0, bus.mem_req_valid}, 32'd0);
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("flw_drop_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("flw_req", {31'd0, bus.mem_req_valid}, 32'd1);
    chk("flw_addr", bus.mem_req_addr, 32'h8000_0200);
    do_fetch(32'h8000_0200, 32'h0070_0393, 0, 1'b0, 32'h0, 1'b1);
    chk("flw_no_stale", {31'd0, saw_bad}, 32'd0);

    // flush beats a consume in the same cycle
    do_fetch(32'h8000_0204, 32'h0080_0413, 0, 1'b0, 32'h0, 1'b0);
    bus.inst_ready  = 1'b1;
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h8000_0300;
    @(negedge clk);
    bus.inst_ready  = 1'b0;
    bus.flush_valid = 1'b0;
    chk("flh_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("flh_req", {31'd0, bus.mem_req_valid}, 32'd1);
    chk("flh_addr", bus.mem_req_addr, 32'h8000_0300);

    do_fetch(32'h8000_0300, EBREAK_INST, 0, 1'b0, 32'h0, 1'b1);
    chk("ebk_halted", {31'd0, bus.halted}, 32'd1);
    chk("ebk_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("ebk_misaligned", {31'd0, bus.misaligned}, 32'd0);
    bus.mem_req_ready = 1'b1;
    no_req("ebk_no_req", 20);
    bus.mem_req_ready = 1'b0;

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_fetch(32'h8000_0000, 32'h0000_0013, 0, 1'b0, 32'h0, 1'b1);
    wait_req();
    chk("mid_addr", bus.mem_req_addr, 32'h8000_0004);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", bus.mem_req_addr, RESET_PC);
    chk("arst_inst", bus.inst, 32'd0);
    chk("arst_inst_pc", bus.inst_pc, RESET_PC);
    chk("arst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("arst_halted", {31'd0, bus.halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // misaligned redirect before the request is accepted
    wait_req();
    chk("mis_addr0", bus.mem_req_addr, RESET_PC);
    bus.flush_valid = 1'b1;
    bus.flush_pc    = 32'h8000_0002;
    @(negedge clk);
    bus.flush_valid = 1'b0;
    chk("mis_flag", {31'd0, bus.misaligned}, 32'd1);
    chk("mis_halted", {31'd0, bus.halted}, 32'd1);
    chk("mis_req", {31'd0, bus.mem_req_valid}, 32'd0);
    bus.mem_req_ready = 1'b1;
    no_req("mis_no_req", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
